// File: rtl/ergene_pkg.sv
// Shared types and constants for the event serializer readout stage.
package ergene_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_CHECK,
    S_SHIFT,
    S_DUMP,
    S_STOP,
    S_DONE
  } ser_state_t;

  localparam logic MARKER_BIT = 1'b1;
  localparam logic STOP_BIT   = 1'b0;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary converter that also flags empty and multi-hot selects.
module onehot_to_bin #(
  parameter int N_CH = 16
) (
  input  logic [N_CH-1:0]         onehot,
  output logic [$clog2(N_CH)-1:0] addr,
  output logic                    valid,
  output logic                    multi
);

  localparam int ADDR_W = $clog2(N_CH);

  logic seen;

  // OR-ing indices gives the address when exactly one bit is set; other cases are flagged.
  always_comb begin
    addr  = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (onehot[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        addr = addr | ADDR_W'(i);
      end
    end
    valid = seen & ~multi;
  end

endmodule

// File: rtl/event_serializer.sv
// Readout frame controller: arms the priority stage, serializes each channel
// address as a marker-prefixed word, and closes the frame with a stop bit.
module event_serializer
  import ergene_pkg::*;
#(
  parameter int N_CH = 16
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    start_i,
  input  logic [N_CH-1:0]         ch_sel_i,
  input  logic                    zero_i,
  input  logic                    stall_i,
  output logic                    arm_o,
  output logic                    dump_o,
  output logic                    sdo_o,
  output logic                    sdo_valid_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic [$clog2(N_CH):0]   event_cnt_o,
  output logic                    err_o
);

  localparam int ADDR_W = $clog2(N_CH);
  localparam int IDX_W  = $clog2(ADDR_W + 1);

  ser_state_t          state, state_next;
  logic [ADDR_W:0]     word;
  logic [IDX_W-1:0]    bit_idx;
  logic [ADDR_W:0]     event_cnt;
  logic                err;

  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_valid;
  logic                sel_multi;

  onehot_to_bin #(.N_CH(N_CH)) u_onehot_to_bin (
    .onehot (ch_sel_i),
    .addr   (sel_addr),
    .valid  (sel_valid),
    .multi  (sel_multi)
  );

  logic last_bit;
  logic cnt_full;
  logic check_ok;
  logic check_err;

  assign last_bit  = (bit_idx == IDX_W'(ADDR_W));
  assign cnt_full  = (event_cnt == (ADDR_W + 1)'(N_CH));
  assign check_ok  = !zero_i && sel_valid && !cnt_full;
  assign check_err = !zero_i && (cnt_full || !sel_valid);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state <= S_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next   = state;
    arm_o        = 1'b0;
    dump_o       = 1'b0;
    sdo_o        = 1'b0;
    sdo_valid_o  = 1'b0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_next = S_ARM;
      end
      S_ARM: begin
        arm_o      = 1'b1;
        state_next = S_SETTLE;
      end
      S_SETTLE: state_next = S_CHECK;
      S_CHECK:  state_next = check_ok ? S_SHIFT : S_STOP;
      S_SHIFT: begin
        sdo_valid_o = 1'b1;
        sdo_o       = word[ADDR_W];
        if (!stall_i && last_bit) state_next = S_DUMP;
      end
      S_DUMP: begin
        dump_o     = 1'b1;
        state_next = S_SETTLE;
      end
      S_STOP: begin
        sdo_valid_o = 1'b1;
        sdo_o       = STOP_BIT;
        if (!stall_i) state_next = S_DONE;
      end
      S_DONE: begin
        frame_done_o = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The word shifts MSB-first so the outgoing bit is always word[ADDR_W].
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      word      <= '0;
      bit_idx   <= '0;
      event_cnt <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            event_cnt <= '0;
            err       <= 1'b0;
          end
        end
        S_CHECK: begin
          bit_idx <= '0;
          if (check_ok)  word <= {MARKER_BIT, sel_addr};
          if (check_err) err  <= 1'b1;
        end
        S_SHIFT: begin
          if (!stall_i) begin
            word <= {word[ADDR_W-1:0], 1'b0};
            if (last_bit) begin
              bit_idx   <= '0;
              event_cnt <= event_cnt + 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign event_cnt_o = event_cnt;
  assign err_o       = err;

endmodule
